// File: rtl/seq_divider_pkg.sv
// Shared encodings for the iterative RV32M divide unit.
// Op values match funct3[1:0] so the decoder can pass them straight through.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

    function automatic logic op_is_signed(input div_op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/adder_n_subtractor.sv
// Generic ripple adder/subtractor: s = b + a when c=0, s = b - a when c=1.
module adder_n_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] s
);

    assign s = b + (a ^ {WIDTH{c}}) + WIDTH'(c);

endmodule

// File: rtl/seq_divider.sv
// Restoring radix-2 divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Works on magnitudes and fixes signs and the divide-by-zero/overflow cases in FIX.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int              CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state, next_state;
    div_op_e          op_q;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem, rem_shift, diff;
    logic [WIDTH-1:0] quo, divisor_q, fix_result;
    logic             neg_quo, neg_rem, div_zero, overflow;

    logic             in_signed, dvd_neg, dvs_neg, in_div_zero, in_overflow;
    logic [WIDTH-1:0] dvd_abs, dvs_abs;

    assign in_signed   = op_is_signed(div_op_e'(op));
    assign dvd_neg     = in_signed & dividend[WIDTH-1];
    assign dvs_neg     = in_signed & divisor[WIDTH-1];
    assign dvd_abs     = dvd_neg ? -dividend : dividend;
    assign dvs_abs     = dvs_neg ? -divisor : divisor;
    assign in_div_zero = (divisor == '0);
    assign in_overflow = in_signed && (dividend == MIN_NEG) && (divisor == '1);

    // rem[WIDTH] is always 0 between steps, so dropping it in the shift loses nothing.
    assign rem_shift = (WIDTH+1)'({rem, quo[WIDTH-1]});

    adder_n_subtractor #(.WIDTH(WIDTH + 1)) u_trial_sub (
        .a ({1'b0, divisor_q}),
        .b (rem_shift),
        .c (1'b1),
        .s (diff)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = (in_div_zero || in_overflow) ? FIX : CALC;
                CALC:    if (count == LAST_ITER) next_state = FIX;
                FIX:     next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Special cases bypass the iteration; quo still holds |dividend| on those paths.
    always_comb begin
        fix_result = '0;
        if (div_zero) begin
            fix_result = op_is_rem(op_q) ? (neg_rem ? -quo : quo) : '1;
        end else if (overflow) begin
            fix_result = op_is_rem(op_q) ? '0 : quo;
        end else if (op_is_rem(op_q)) begin
            fix_result = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        end else begin
            fix_result = neg_quo ? -quo : quo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_DIV;
            count     <= '0;
            rem       <= '0;
            quo       <= '0;
            divisor_q <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
            result    <= '0;
        end else if (!abort) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= div_op_e'(op);
                        count     <= '0;
                        rem       <= '0;
                        quo       <= dvd_abs;
                        divisor_q <= dvs_abs;
                        neg_quo   <= dvd_neg ^ dvs_neg;
                        neg_rem   <= dvd_neg;
                        div_zero  <= in_div_zero;
                        overflow  <= in_overflow;
                    end
                end
                CALC: begin
                    rem   <= diff[WIDTH] ? rem_shift : diff;
                    quo   <= {quo[WIDTH-2:0], ~diff[WIDTH]};
                    count <= count + CW'(1);
                end
                FIX: begin
                    result <= fix_result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: arithmetic, special cases,
// handshake timing, abort and asynchronous reset.
module tb_seq_divider;

    localparam int W           = 32;
    localparam int FULL_EDGES  = W + 2;
    localparam int SHORT_EDGES = 2;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s);
        op       = o;
        dividend = a;
        divisor  = b;
        start    = s;
    endtask

    // Drive a start in an IDLE cycle, then scramble operands right after the accepting edge.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        applyStimulus(o, a, b, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(~o, ~a, b ^ 32'h5A5A_A5A5, 1'b0);
    endtask

    // Counts edges from the accepting edge (counted as 1) until done is seen.
    task automatic waitDone(output int edges, output logic seen, output logic busy_ok);
        edges   = 1;
        seen    = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            busy_ok &= busy;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic runOp(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_edges);
        int   edges;
        logic seen;
        logic busy_ok;
        launch(o, a, b);
        waitDone(edges, seen, busy_ok);
        checkOutput({tag, "_done"}, {31'b0, seen}, 32'd1);
        checkOutput({tag, "_edges"}, W'(edges), W'(exp_edges));
        checkOutput({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
        checkOutput({tag, "_res"}, result, exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        int   edges;
        int   done_hits;
        logic seen;
        logic busy_ok;

        #1;
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        #12;
        @(negedge clk);
        rst_n = 1'b1;

        runOp("divu_100_7",   DIVU, 32'd100,        32'd7,          32'd14,         FULL_EDGES);
        runOp("remu_100_7",   REMU, 32'd100,        32'd7,          32'd2,          FULL_EDGES);
        runOp("div_m100_7",   DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  FULL_EDGES);
        runOp("rem_m100_7",   REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  FULL_EDGES);
        runOp("rem_100_m7",   REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          FULL_EDGES);
        runOp("div_m100_m7",  DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         FULL_EDGES);
        runOp("div_5_0",      DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  SHORT_EDGES);
        runOp("remu_5_0",     REMU, 32'd5,          32'd0,          32'd5,          SHORT_EDGES);
        runOp("rem_m5_0",     REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  SHORT_EDGES);
        runOp("div_ovf",      DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SHORT_EDGES);
        runOp("rem_ovf",      REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          SHORT_EDGES);
        runOp("divu_max_1",   DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  FULL_EDGES);
        runOp("remu_min_max", REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  FULL_EDGES);

        // start pulsed mid-CALC with different operands must be ignored
        launch(DIVU, 32'd1000, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        applyStimulus(DIV, 32'd12345, 32'd3, 1'b1);
        @(negedge clk);
        applyStimulus(DIV, 32'd0, 32'd0, 1'b0);
        waitDone(edges, seen, busy_ok);
        checkOutput("ignore_done", {31'b0, seen}, 32'd1);
        checkOutput("ignore_res", result, 32'd142);

        // back-to-back: second start held from the DONE cycle, accepted in the following IDLE cycle
        launch(DIVU, 32'd1000, 32'd10);
        waitDone(edges, seen, busy_ok);
        checkOutput("b2b_first_res", result, 32'd100);
        applyStimulus(REMU, 32'd1000, 32'd7, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("b2b_gap_idle", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(DIV, 32'd77, 32'd0, 1'b0);
        checkOutput("b2b_accepted", {31'b0, busy}, 32'd1);
        waitDone(edges, seen, busy_ok);
        checkOutput("b2b_second_done", {31'b0, seen}, 32'd1);
        checkOutput("b2b_second_edges", W'(edges), W'(FULL_EDGES));
        checkOutput("b2b_second_res", result, 32'd6);

        // abort in CALC cycle 10: back to IDLE, no done, result keeps 6
        launch(DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort_idle", {31'b0, busy}, 32'd0);
        done_hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_hits++;
        end
        checkOutput("abort_no_done", W'(done_hits), 32'd0);
        checkOutput("abort_res_kept", result, 32'd6);

        // abort beats start in the same IDLE cycle
        @(negedge clk);
        applyStimulus(DIVU, 32'd9, 32'd3, 1'b1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        checkOutput("abort_vs_start", {31'b0, busy}, 32'd0);

        // asynchronous reset mid-CALC clears outputs without waiting for an edge
        launch(DIVU, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", {31'b0, busy}, 32'd0);
        checkOutput("arst_done", {31'b0, done}, 32'd0);
        checkOutput("arst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp("post_rst_div", DIV, 32'd1000, 32'd3, 32'd333, FULL_EDGES);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
